regbank_seq_ctrl: RTL

Sequencer that drives the control and address inputs of the 64x32 register bank, one instruction at a time. It accepts decoded ops (ALU, load-immediate, load, store) over a valid/ready handshake. It then emits the correctly timed single-cycle strobes and holds register indices stable through the data-memory load latency. It sits between instruction decode and the register bank, and also keeps a retired-op counter for debug.

---
 rtl/regbank_seq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/regbank_seq_ctrl.sv
// Issue sequencer for the 64x32 register bank: takes one decoded op at a time and
// produces single-cycle bank strobes with indices held stable through load latency.
module regbank_seq_ctrl #(
  parameter int RD_LAT = 3,   // must be >= 1
  parameter int AW     = 6,
  parameter int CW     = 31,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_kind,
  input  logic [3:0]       op_alu,
  input  logic [AW-1:0]    op_dst,
  input  logic [AW-1:0]    op_src,
  input  logic [AW-1:0]    op_src2,
  input  logic [CW-1:0]    op_const,
  output logic [AW-1:0]    bank_src,
  output logic [AW-1:0]    bank_src2,
  output logic [AW-1:0]    bank_dst,
  output logic [AW-1:0]    bank_dstld,
  output logic [CW-1:0]    bank_const,
  output logic [3:0]       bank_opcode,
  output logic             bank_ld,
  output logic             bank_write,
  output logic             bank_read,
  output logic             bank_write_alu,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] K_ALU   = 2'b00;
  localparam logic [1:0] K_LDI   = 2'b01;
  localparam logic [1:0] K_LOAD  = 2'b10;
  localparam logic [1:0] K_STORE = 2'b11;

  typedef enum logic [2:0] {
    IDLE, ALU_EX, ALU_WB, LDI, STORE, LOAD, LD_WAIT
  } state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic           accept;
  logic           done_nxt;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid && op_ready) begin
          accept = 1'b1;
          case (op_kind)
            K_ALU:   state_nxt = ALU_EX;
            K_LDI:   state_nxt = LDI;
            K_LOAD:  state_nxt = LOAD;
            default: state_nxt = STORE;
          endcase
        end
      end
      ALU_EX:  state_nxt = ALU_WB;
      ALU_WB:  state_nxt = IDLE;
      LDI:     state_nxt = IDLE;
      STORE:   state_nxt = IDLE;
      LOAD: begin
        state_nxt = LD_WAIT;
        wcnt_nxt  = WCW'(RD_LAT - 1);
      end
      LD_WAIT: begin
        if (wcnt == '0) state_nxt = IDLE;
        else            wcnt_nxt  = wcnt - WCW'(1);
      end
      default: state_nxt = IDLE;
    endcase
    // The last cycle of an op is where the retire count advances; for loads
    // that is the wait cycle in which the bank captures the returning data.
    done_nxt = (state_nxt == ALU_WB) || (state_nxt == LDI) || (state_nxt == STORE) ||
               ((state_nxt == LD_WAIT) && (wcnt_nxt == '0));
  end

  // Every output is a flop fed from the next-state decode, so strobes line up
  // with the state they belong to without any combinational path to the bank.
  always_ff @(posedge clk) begin
    if (RST) begin
      state          <= IDLE;
      wcnt           <= '0;
      op_ready       <= 1'b0;
      busy           <= 1'b0;
      bank_ld        <= 1'b0;
      bank_write     <= 1'b0;
      bank_read      <= 1'b0;
      bank_write_alu <= 1'b0;
      bank_src       <= '0;
      bank_src2      <= '0;
      bank_dst       <= '0;
      bank_dstld     <= '0;
      bank_const     <= '0;
      bank_opcode    <= '0;
      retired        <= '0;
    end else begin
      state          <= state_nxt;
      wcnt           <= wcnt_nxt;
      op_ready       <= (state_nxt == IDLE);
      busy           <= (state_nxt != IDLE);
      bank_ld        <= (state_nxt == LDI);
      bank_write     <= (state_nxt == STORE);
      bank_read      <= (state_nxt == LOAD);
      bank_write_alu <= (state_nxt == ALU_WB);
      if (done_nxt) retired <= retired + CNT_W'(1);
      // Only the fields an op actually uses are captured; the rest keep
      // whatever the previous op left there.
      if (accept) begin
        case (op_kind)
          K_ALU: begin
            bank_src    <= op_src;
            bank_src2   <= op_src2;
            bank_dst    <= op_dst;
            bank_opcode <= op_alu;
          end
          K_LDI: begin
            bank_dstld <= op_dst;
            bank_const <= op_const;
          end
          K_LOAD: begin
            bank_src2 <= op_src2;
            bank_dst  <= op_dst;
          end
          default: begin
            bank_src  <= op_src;
            bank_src2 <= op_src2;
          end
        endcase
      end
    end
  end

endmodule
